key_event_queue: RTL and testbench

//  Reader side of the debounced-key path. Collects one-cycle key pulses from the
//  per-button debouncers (left/right/rotate/down/drop) and encodes each as a key

---
 rtl/key_event_queue_pkg.sv | 19 +
 rtl/key_event_queue_evt_fifo.sv | 63 ++++++
 rtl/key_event_queue.sv | 115 +++++++++++
 tb/tb_key_event_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_queue_pkg.sv
// Shared key codes and default sizing for the key event queue.
// The game FSM decodes ev_code against the KEY_* values below.
package key_event_queue_pkg;

  localparam int KEY_CODE_W = 3;

  typedef enum logic [KEY_CODE_W-1:0] {
    KEY_LEFT   = 3'd0,
    KEY_RIGHT  = 3'd1,
    KEY_ROTATE = 3'd2,
    KEY_DOWN   = 3'd3,
    KEY_DROP   = 3'd4
  } key_code_e;

  localparam int KQ_NUM_KEYS = 5;
  localparam int KQ_DEPTH    = 4;
  localparam int KQ_DROP_W   = 8;

endpackage

// File: rtl/key_event_queue_evt_fifo.sv
// Register-array synchronous FIFO with flush; head is read combinationally
// from the register array so it is valid in the same cycle count becomes non-zero.
module evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/key_event_queue.sv
// Collects one-cycle key pulses into a pending vector, serialises them lowest
// index first into an event FIFO and counts presses coalesced while still pending.
module key_event_queue
  import key_event_queue_pkg::*;
#(
  parameter int NUM_KEYS = KQ_NUM_KEYS,
  parameter int CODE_W   = KEY_CODE_W,
  parameter int DEPTH    = KQ_DEPTH,
  parameter int DROP_W   = KQ_DROP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_KEYS-1:0]      i_key_pulse,
  input  logic                     i_flush,
  output logic                     o_ev_valid,
  output logic [CODE_W-1:0]        o_ev_code,
  input  logic                     i_ev_ready,
  output logic                     o_overflow,
  output logic [DROP_W-1:0]        o_drop_cnt,
  output logic [NUM_KEYS-1:0]      o_pend,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int NCNT_W = $clog2(NUM_KEYS + 1);
  localparam int SUM_W  = ((DROP_W > NCNT_W) ? DROP_W : NCNT_W) + 1;

  logic [NUM_KEYS-1:0] r_pend;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic [NUM_KEYS-1:0] w_lowest;
  logic [NUM_KEYS-1:0] w_grant;
  logic [CODE_W-1:0]   w_grant_idx;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CODE_W-1:0]   w_head;
  logic [NUM_KEYS-1:0] w_drop_vec;
  logic [NCNT_W-1:0]   w_drop_num;
  logic [SUM_W-1:0]    w_drop_sum;
  logic [DROP_W-1:0]   w_drop_nxt;

  // Handshake: an event transfers on every cycle where o_ev_valid and i_ev_ready
  // are both high; while valid is high and ready low, the head code stays put.
  assign w_pop = ~w_empty & i_ev_ready;

  assign w_lowest = r_pend & (~r_pend + NUM_KEYS'(1));
  assign w_push   = (|r_pend) & (~w_full | w_pop);
  assign w_grant  = w_push ? w_lowest : '0;

  always_comb begin
    w_grant_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_grant_idx = CODE_W'(i);
    end
  end

  // A press is lost only when its key is already pending and not leaving this cycle.
  assign w_drop_vec = i_key_pulse & r_pend & ~w_grant;

  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_drop_num = w_drop_num + NCNT_W'(w_drop_vec[i]);
    end
  end

  always_comb begin
    w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_num);
    if (w_drop_sum > SUM_W'({DROP_W{1'b1}})) w_drop_nxt = '1;
    else                                     w_drop_nxt = w_drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_flush) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | i_key_pulse;
      if (|w_drop_vec) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_nxt;
      end
    end
  end

  evt_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_grant_idx),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_count)
  );

  assign o_ev_valid = ~w_empty;
  assign o_ev_code  = w_head;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;
  assign o_pend     = r_pend;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: latency, serialisation, full-FIFO hold,
// coalescing, flush priority, drop saturation and asynchronous reset.
module tb_key_event_queue;
  import key_event_queue_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] i_key_pulse;
  logic       i_flush;
  logic       i_ev_ready;

  logic       ev_valid,  s_ev_valid;
  logic [2:0] ev_code,   s_ev_code;
  logic       overflow,  s_overflow;
  logic [7:0] drop_cnt;
  logic [1:0] s_drop_cnt;
  logic [4:0] pend,      s_pend;
  logic [2:0] count,     s_count;

  int n_vec;
  int n_err;

  key_event_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_key_pulse (i_key_pulse),
    .i_flush     (i_flush),
    .o_ev_valid  (ev_valid),
    .o_ev_code   (ev_code),
    .i_ev_ready  (i_ev_ready),
    .o_overflow  (overflow),
    .o_drop_cnt  (drop_cnt),
    .o_pend      (pend),
    .o_count     (count)
  );

  key_event_queue #(.DROP_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_key_pulse (i_key_pulse),
    .i_flush     (i_flush),
    .o_ev_valid  (s_ev_valid),
    .o_ev_code   (s_ev_code),
    .i_ev_ready  (i_ev_ready),
    .o_overflow  (s_overflow),
    .o_drop_cnt  (s_drop_cnt),
    .o_pend      (s_pend),
    .o_count     (s_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input logic [4:0] vec);
    i_key_pulse = vec;
    tick();
    i_key_pulse = '0;
  endtask

  task automatic do_flush();
    i_ev_ready = 1'b0;
    i_flush    = 1'b1;
    tick();
    i_flush    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    i_key_pulse = '0;
    i_flush     = 1'b0;
    i_ev_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (ev_valid !== 1'b0 || ev_code !== 3'd0 || overflow !== 1'b0 ||
        drop_cnt !== 8'd0 || pend !== 5'd0 || count !== 3'd0) begin
      n_err++;
      $display("FAIL reset: valid=%b code=%0d ovf=%b drop=%0d pend=%b count=%0d, required all 0",
               ev_valid, ev_code, overflow, drop_cnt, pend, count);
    end
  endtask

  task automatic test_latency();
    do_flush();
    i_ev_ready = 1'b1;
    drive_pulse(5'b00100);
    n_vec++;
    if (ev_valid !== 1'b0 || pend !== 5'b00100) begin
      n_err++;
      $display("FAIL latency_e0: valid=%b pend=%b, required 0 / 00100", ev_valid, pend);
    end
    tick();
    n_vec++;
    if (ev_valid !== 1'b1 || ev_code !== KEY_ROTATE) begin
      n_err++;
      $display("FAIL latency_e1: valid=%b code=%0d, required 1 / 2", ev_valid, ev_code);
    end
    tick();
    n_vec++;
    if (ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_e2: valid=%b, required 0", ev_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_q[$];
    do_flush();
    exp_q = '{3'd0, 3'd3, 3'd4};
    i_ev_ready = 1'b1;
    drive_pulse(5'b11001);
    tick();
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (ev_valid !== 1'b1 || ev_code !== exp_q[k]) begin
        n_err++;
        $display("FAIL simult_%0d: valid=%b code=%0d, required 1 / %0d", k, ev_valid, ev_code, exp_q[k]);
      end
      tick();
    end
    n_vec++;
    if (ev_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL simult_end: valid=%b ovf=%b, required 0 / 0", ev_valid, overflow);
    end
  endtask

  task automatic test_fill_order();
    do_flush();
    for (int k = 0; k < 5; k++) drive_pulse(5'(1 << k));
    tick();
    n_vec++;
    if (count !== 3'd4 || pend !== 5'b10000 || ev_code !== KEY_LEFT) begin
      n_err++;
      $display("FAIL fill_state: count=%0d pend=%b head=%0d, required 4 / 10000 / 0", count, pend, ev_code);
    end
    i_ev_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (ev_valid !== 1'b1 || ev_code !== 3'(k)) begin
        n_err++;
        $display("FAIL fill_drain_%0d: valid=%b code=%0d, required 1 / %0d", k, ev_valid, ev_code, k);
      end
      tick();
    end
    n_vec++;
    if (ev_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL fill_end: valid=%b drop=%0d, required 0 / 0", ev_valid, drop_cnt);
    end
  endtask

  task automatic test_coalesce();
    logic [2:0] exp_q[$];
    do_flush();
    exp_q = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd1};
    drive_pulse(5'b00001);
    drive_pulse(5'b00100);
    drive_pulse(5'b01000);
    drive_pulse(5'b10000);
    drive_pulse(5'b00010);
    drive_pulse(5'b00010);
    n_vec++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1 || pend !== 5'b00010 || count !== 3'd4) begin
      n_err++;
      $display("FAIL coalesce_state: ovf=%b drop=%0d pend=%b count=%0d, required 1 / 1 / 00010 / 4",
               overflow, drop_cnt, pend, count);
    end
    i_ev_ready = 1'b1;
    while (exp_q.size() > 0) begin
      n_vec++;
      if (ev_valid !== 1'b1 || ev_code !== exp_q[0]) begin
        n_err++;
        $display("FAIL coalesce_drain: valid=%b code=%0d, required 1 / %0d", ev_valid, ev_code, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (ev_valid !== 1'b0) begin
        n_err++;
        $display("FAIL coalesce_extra: valid=%b code=%0d, required valid 0", ev_valid, ev_code);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_flush();
    for (int k = 0; k < 5; k++) drive_pulse(5'(1 << k));
    drive_pulse(5'b10000);
    n_vec++;
    if (drop_cnt !== 8'd1 || count !== 3'd4) begin
      n_err++;
      $display("FAIL flush_setup: drop=%0d count=%0d, required 1 / 4", drop_cnt, count);
    end
    i_flush     = 1'b1;
    i_key_pulse = 5'b00001;
    i_ev_ready  = 1'b1;
    tick();
    i_flush     = 1'b0;
    i_key_pulse = '0;
    n_vec++;
    if (ev_valid !== 1'b0 || pend !== 5'd0 || drop_cnt !== 8'd0 ||
        overflow !== 1'b0 || count !== 3'd0) begin
      n_err++;
      $display("FAIL flush_clear: valid=%b pend=%b drop=%0d ovf=%b count=%0d, required all 0",
               ev_valid, pend, drop_cnt, overflow, count);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (ev_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_after: valid=%b code=%0d, required valid 0", ev_valid, ev_code);
      end
    end
  endtask

  task automatic test_saturate_and_async_reset();
    do_flush();
    drive_pulse(5'b00001);
    drive_pulse(5'b00100);
    drive_pulse(5'b01000);
    drive_pulse(5'b10000);
    drive_pulse(5'b00010);
    for (int k = 0; k < 5; k++) drive_pulse(5'b00010);
    n_vec++;
    if (drop_cnt !== 8'd5 || s_drop_cnt !== 2'd3 || s_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: drop=%0d sat_drop=%0d sat_ovf=%b, required 5 / 3 / 1",
               drop_cnt, s_drop_cnt, s_overflow);
    end
    i_ev_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if (ev_valid !== 1'b1 || ev_code !== KEY_DOWN) begin
      n_err++;
      $display("FAIL mid_drain: valid=%b code=%0d, required 1 / 3", ev_valid, ev_code);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ev_valid !== 1'b0 || ev_code !== 3'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0 ||
        pend !== 5'd0 || count !== 3'd0 || s_drop_cnt !== 2'd0 || s_ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b code=%0d ovf=%b drop=%0d pend=%b count=%0d sat_drop=%0d, required all 0",
               ev_valid, ev_code, overflow, drop_cnt, pend, count, s_drop_cnt);
    end
    i_ev_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_latency();
    test_simultaneous();
    test_fill_order();
    test_coalesce();
    test_flush();
    test_saturate_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
